// File: rtl/music_box_pkg.sv
// Shared types and defaults for the tone generator: wave selection codes,
// controller states, default timing/width constants and the wave shaper.
package music_box_pkg;

  typedef enum logic [1:0] {
    WAVE_SQUARE = 2'd0,
    WAVE_SAW    = 2'd1,
    WAVE_TRI    = 2'd2,
    WAVE_SILENT = 2'd3
  } wave_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAVE  = 2'd1,
    SCALE = 2'd2
  } tone_state_t;

  localparam int DEF_TICK_DIV      = 1562;
  localparam int DEF_ACC_W         = 24;
  localparam int DEF_INC_MULT      = 524;
  localparam int DEF_STABLE_CYCLES = 4;
  localparam int FREQ_W            = 14;
  localparam int AMP_W             = 8;

  // Maps the top 9 phase bits to an unsigned 8-bit waveform value.
  function automatic logic [7:0] wave_lookup(input wave_t sel, input logic [8:0] p);
    logic [7:0] w;
    w = 8'd0;
    case (sel)
      WAVE_SQUARE: w = p[8] ? 8'd0 : 8'd255;
      WAVE_SAW:    w = p[8:1];
      WAVE_TRI:    w = p[8] ? ~p[7:0] : p[7:0];
      default:     w = 8'd0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/arduino_tone_generator_if.sv
// Sample-path bundle between the SPI front end / DAC stage and the tone
// generator. The generator side uses the slave modport.
interface arduino_tone_generator_if;
  import music_box_pkg::*;

  logic [FREQ_W-1:0] inputFrequencySample;
  logic [AMP_W-1:0]  inputAmplitudeSample;
  logic [1:0]        waveSelect;
  logic [7:0]        outputSample;
  logic              outputSampleValid;
  logic              outputTick;

  modport master (
    output inputFrequencySample,
    output inputAmplitudeSample,
    output waveSelect,
    input  outputSample,
    input  outputSampleValid,
    input  outputTick
  );

  modport slave (
    input  inputFrequencySample,
    input  inputAmplitudeSample,
    input  waveSelect,
    output outputSample,
    output outputSampleValid,
    output outputTick
  );

endinterface

// File: rtl/bus_stabilizer.sv
// Brings an asynchronous multi-bit word into the local clock domain and only
// accepts it once the synced value has been steady for STABLE_CYCLES
// consecutive compares. A steady input reaches pending 2+STABLE_CYCLES+1
// cycles after it first changes; a bus that keeps moving never loads.
module bus_stabilizer #(
  parameter int W             = 8,
  parameter int STABLE_CYCLES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  output logic [W-1:0] pending
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [W-1:0]     sync1;
  logic [W-1:0]     sync2;
  logic [W-1:0]     prev;
  logic [CNT_W-1:0] stable_cnt;

  // Two-flop sync, history compare, saturating stable count and pending load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1      <= '0;
      sync2      <= '0;
      prev       <= '0;
      stable_cnt <= '0;
      pending    <= '0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      prev  <= sync2;
      if (sync2 != prev) begin
        stable_cnt <= '0;
      end else if (stable_cnt != CNT_MAX) begin
        stable_cnt <= stable_cnt + CNT_ONE;
        // Load on the compare that brings the count to its ceiling.
        if (stable_cnt == CNT_MAX - CNT_ONE) begin
          pending <= sync2;
        end
      end
    end
  end

endmodule

// File: rtl/arduino_tone_generator.sv
// Phase-accumulator tone generator. Stabilized frequency/amplitude words are
// latched on each sample tick; the phase steps with the previous tick's
// frequency, then a two-stage pipeline shapes and scales one sample per tick.
//
//   state | meaning
//   IDLE  | waiting for the sample tick
//   WAVE  | shape top phase bits into wave8 (S1)
//   SCALE | multiply by amplitude, strobe valid (S2)
//
// TICK_DIV must be at least 3 so a tick can only land while in IDLE.
module arduino_tone_generator
  import music_box_pkg::*;
#(
  parameter int TICK_DIV      = DEF_TICK_DIV,
  parameter int ACC_W         = DEF_ACC_W,
  parameter int INC_MULT      = DEF_INC_MULT,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
) (
  input logic                     CLK_50Mhz,
  input logic                     reset_n,
  arduino_tone_generator_if.slave bus
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam int INC_W = FREQ_W + 10;

  logic [FREQ_W-1:0] pend_freq;
  logic [FREQ_W-1:0] acc_freq;
  logic [AMP_W-1:0]  pend_amp;
  logic [AMP_W-1:0]  acc_amp;
  logic [1:0]        wave_s1;
  logic [1:0]        wave_s2;
  logic [CNT_W-1:0]  tick_cnt;
  logic              tick;
  logic              tick_q;
  logic [ACC_W-1:0]  phase;
  logic [INC_W-1:0]  inc_full;
  logic [ACC_W-1:0]  phase_inc;
  logic [7:0]        wave8;
  logic [15:0]       product;
  logic [7:0]        sample;
  logic              sample_valid;
  tone_state_t       state;
  tone_state_t       state_nxt;
  logic              wave_load;
  logic              scale_load;

  bus_stabilizer #(.W(FREQ_W), .STABLE_CYCLES(STABLE_CYCLES)) u_freq_stab (
    .clk     (CLK_50Mhz),
    .rst_n   (reset_n),
    .din     (bus.inputFrequencySample),
    .pending (pend_freq)
  );

  bus_stabilizer #(.W(AMP_W), .STABLE_CYCLES(STABLE_CYCLES)) u_amp_stab (
    .clk     (CLK_50Mhz),
    .rst_n   (reset_n),
    .din     (bus.inputAmplitudeSample),
    .pending (pend_amp)
  );

  assign tick      = (tick_cnt == TICK_LAST);
  assign inc_full  = {10'd0, acc_freq} * INC_W'(INC_MULT);
  assign phase_inc = ACC_W'(inc_full);
  assign product   = {8'd0, wave8} * {8'd0, acc_amp};

  assign bus.outputSample      = sample;
  assign bus.outputSampleValid = sample_valid;
  assign bus.outputTick        = tick_q;

  // Wave select is quasi-static; a plain two-flop sync is enough.
  always_ff @(posedge CLK_50Mhz or negedge reset_n) begin
    if (!reset_n) begin
      wave_s1 <= 2'd0;
      wave_s2 <= 2'd0;
    end else begin
      wave_s1 <= bus.waveSelect;
      wave_s2 <= wave_s1;
    end
  end

  // Sample-rate divider: counts 0..TICK_DIV-1 and registers the tick pulse.
  always_ff @(posedge CLK_50Mhz or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt <= '0;
      tick_q   <= 1'b0;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + CNT_ONE;
      tick_q   <= tick;
    end
  end

  // On tick: latch new settings and step the phase with the outgoing frequency.
  always_ff @(posedge CLK_50Mhz or negedge reset_n) begin
    if (!reset_n) begin
      acc_freq <= '0;
      acc_amp  <= '0;
      phase    <= '0;
    end else if (tick) begin
      acc_freq <= pend_freq;
      acc_amp  <= pend_amp;
      phase    <= (acc_freq == '0) ? '0 : phase + phase_inc;
    end
  end

  // Controller state register.
  always_ff @(posedge CLK_50Mhz or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Controller next-state and stage enables.
  always_comb begin
    state_nxt  = state;
    wave_load  = 1'b0;
    scale_load = 1'b0;
    case (state)
      IDLE: begin
        if (tick) state_nxt = WAVE;
      end
      WAVE: begin
        wave_load = 1'b1;
        state_nxt = SCALE;
      end
      SCALE: begin
        scale_load = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // S1: shape the phase; a zero frequency mutes the oscillator.
  always_ff @(posedge CLK_50Mhz or negedge reset_n) begin
    if (!reset_n) begin
      wave8 <= 8'd0;
    end else if (wave_load) begin
      wave8 <= (acc_freq == '0) ? 8'd0
                                : wave_lookup(wave_t'(wave_s2), phase[ACC_W-1 -: 9]);
    end
  end

  // S2: amplitude scale and one-cycle valid strobe.
  always_ff @(posedge CLK_50Mhz or negedge reset_n) begin
    if (!reset_n) begin
      sample       <= 8'd0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= scale_load;
      if (scale_load) begin
        sample <= product[15:8];
      end
    end
  end

endmodule

// File: tb/tb_arduino_tone_generator.sv
// Directed bench for the tone generator: tick cadence, waveform values,
// amplitude scaling, input stabilization, phase wrap and mid-run reset.
module tb_arduino_tone_generator;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  arduino_tone_generator_if tone_if ();

  arduino_tone_generator dut (
    .CLK_50Mhz (clk),
    .reset_n   (rst_n),
    .bus       (tone_if)
  );

  always #10 clk = ~clk;

  task automatic apply_reset(input logic [13:0] f, input logic [7:0] a, input logic [1:0] w);
    @(negedge clk);
    rst_n = 1'b0;
    tone_if.inputFrequencySample = f;
    tone_if.inputAmplitudeSample = a;
    tone_if.waveSelect = w;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Waits (bounded) for the next tick and reads the sample two cycles later.
  task automatic capture_sample(output logic [7:0] s, output bit ok);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    ok = 1'b0;
    s = 8'hxx;
    while (n < 2000 && !seen) begin
      @(negedge clk);
      n++;
      if (tone_if.outputTick === 1'b1) seen = 1'b1;
    end
    if (seen) begin
      @(negedge clk);
      @(negedge clk);
      ok = (tone_if.outputSampleValid === 1'b1);
      s = tone_if.outputSample;
    end
  endtask

  task automatic test_reset();
    tone_if.inputFrequencySample = 14'd0;
    tone_if.inputAmplitudeSample = 8'd0;
    tone_if.waveSelect = 2'd0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (tone_if.outputSample !== 8'd0) begin
      fails++; $display("FAIL reset_sample: got %0d expected 0", tone_if.outputSample);
    end
    tests++;
    if (tone_if.outputSampleValid !== 1'b0) begin
      fails++; $display("FAIL reset_valid: got %b expected 0", tone_if.outputSampleValid);
    end
    tests++;
    if (tone_if.outputTick !== 1'b0) begin
      fails++; $display("FAIL reset_tick: got %b expected 0", tone_if.outputTick);
    end
  endtask

  task automatic test_tick_cadence();
    int n;
    apply_reset(14'd0, 8'd255, 2'd0);
    n = 0;
    while (n < 2000) begin
      @(negedge clk); n++;
      if (tone_if.outputTick === 1'b1) break;
    end
    tests++;
    if (n !== 1562) begin
      fails++; $display("FAIL first_tick: got %0d cycles expected 1562", n);
    end
    @(negedge clk);
    tests++;
    if (tone_if.outputTick !== 1'b0 || tone_if.outputSampleValid !== 1'b0) begin
      fails++; $display("FAIL tick_plus1: got tick=%b valid=%b expected 0/0",
                        tone_if.outputTick, tone_if.outputSampleValid);
    end
    @(negedge clk);
    tests++;
    if (tone_if.outputSampleValid !== 1'b1) begin
      fails++; $display("FAIL valid_at_2: got %b expected 1", tone_if.outputSampleValid);
    end
    tests++;
    if (tone_if.outputSample !== 8'd0) begin
      fails++; $display("FAIL zero_freq_sample: got %0d expected 0", tone_if.outputSample);
    end
    @(negedge clk);
    tests++;
    if (tone_if.outputSampleValid !== 1'b0) begin
      fails++; $display("FAIL valid_width: got %b expected 0", tone_if.outputSampleValid);
    end
    n = 3;
    while (n < 2000) begin
      @(negedge clk); n++;
      if (tone_if.outputTick === 1'b1) break;
    end
    tests++;
    if (n !== 1562) begin
      fails++; $display("FAIL tick_period: got %0d cycles expected 1562", n);
    end
  endtask

  task automatic test_square();
    logic [7:0] samp [0:17];
    bit ok;
    bit all_ok;
    bit all_legal;
    all_ok = 1'b1;
    all_legal = 1'b1;
    apply_reset(14'd1000, 8'd255, 2'd0);
    for (int k = 0; k < 18; k++) begin
      capture_sample(samp[k], ok);
      if (!ok) all_ok = 1'b0;
      if (samp[k] !== 8'd0 && samp[k] !== 8'd254) all_legal = 1'b0;
    end
    tests++;
    if (!all_ok) begin
      fails++; $display("FAIL square_strobes: got missing tick/valid expected 18 samples");
    end
    tests++;
    if (!all_legal) begin
      fails++; $display("FAIL square_levels: got a value outside {0,254} expected only 0 or 254");
    end
    tests++;
    if (samp[0] !== 8'd254) begin
      fails++; $display("FAIL square_k0: got %0d expected 254", samp[0]);
    end
    tests++;
    if (samp[1] !== 8'd254) begin
      fails++; $display("FAIL square_k1: got %0d expected 254", samp[1]);
    end
    tests++;
    if (samp[16] !== 8'd254) begin
      fails++; $display("FAIL square_k16: got %0d expected 254", samp[16]);
    end
    tests++;
    if (samp[17] !== 8'd0) begin
      fails++; $display("FAIL square_k17: got %0d expected 0", samp[17]);
    end
  endtask

  task automatic test_amp_scaling();
    logic [7:0] exp_v [0:3];
    logic [7:0] s;
    bit ok;
    exp_v[0] = 8'd0; exp_v[1] = 8'd50; exp_v[2] = 8'd100; exp_v[3] = 8'd22;
    apply_reset(14'd12507, 8'd128, 2'd1);
    for (int k = 0; k < 4; k++) begin
      capture_sample(s, ok);
      tests++;
      if (!ok || s !== exp_v[k]) begin
        fails++; $display("FAIL saw_amp128_k%0d: got %0d valid_ok=%0d expected %0d", k, s, ok, exp_v[k]);
      end
    end
    tone_if.inputAmplitudeSample = 8'd0;
    for (int k = 4; k < 6; k++) begin
      capture_sample(s, ok);
      tests++;
      if (!ok || s !== 8'd0) begin
        fails++; $display("FAIL amp_zero_k%0d: got %0d valid_ok=%0d expected 0", k, s, ok);
      end
    end
  endtask

  task automatic test_stability();
    bit moved;
    bit seen;
    int n;
    logic [13:0] p6;
    logic [13:0] p7;
    apply_reset(14'd0, 8'd0, 2'd3);
    repeat (20) @(negedge clk);
    moved = 1'b0;
    for (int i = 0; i < 17; i++) begin
      tone_if.inputFrequencySample = (i % 2) ? 14'd500 : 14'd501;
      repeat (3) begin
        @(negedge clk);
        if (dut.u_freq_stab.pending !== 14'd0) moved = 1'b1;
      end
    end
    tests++;
    if (moved) begin
      fails++; $display("FAIL toggle_filtered: got pending update expected none");
    end
    tone_if.inputFrequencySample = 14'd500;
    p6 = 14'd0;
    p7 = 14'd0;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c == 6) p6 = dut.u_freq_stab.pending;
      if (c == 7) p7 = dut.u_freq_stab.pending;
    end
    tests++;
    if (p6 !== 14'd0) begin
      fails++; $display("FAIL pending_early: got %0d at 6 cycles expected 0", p6);
    end
    tests++;
    if (p7 !== 14'd500) begin
      fails++; $display("FAIL pending_7: got %0d at 7 cycles expected 500", p7);
    end
    tests++;
    if (dut.acc_freq !== 14'd0) begin
      fails++; $display("FAIL apply_before_tick: got %0d expected 0", dut.acc_freq);
    end
    n = 0;
    seen = 1'b0;
    while (n < 2000 && !seen) begin
      @(negedge clk); n++;
      if (tone_if.outputTick === 1'b1) seen = 1'b1;
    end
    tests++;
    if (!seen || dut.acc_freq !== 14'd500) begin
      fails++; $display("FAIL apply_at_tick: got %0d tick_seen=%0d expected 500", dut.acc_freq, seen);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_v [0:3];
    logic [7:0] s;
    bit ok;
    exp_v[0] = 8'd0; exp_v[1] = 8'd249; exp_v[2] = 8'd10; exp_v[3] = 8'd237;
    apply_reset(14'd16383, 8'd255, 2'd2);
    for (int k = 0; k < 4; k++) begin
      capture_sample(s, ok);
      tests++;
      if (!ok || s !== exp_v[k]) begin
        fails++; $display("FAIL tri_wrap_k%0d: got %0d valid_ok=%0d expected %0d", k, s, ok, exp_v[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] s;
    bit ok;
    bit seen;
    bit stray;
    int n;
    apply_reset(14'd1000, 8'd255, 2'd0);
    capture_sample(s, ok);
    tests++;
    if (!ok || s !== 8'd254) begin
      fails++; $display("FAIL pre_reset_sample: got %0d valid_ok=%0d expected 254", s, ok);
    end
    n = 0;
    seen = 1'b0;
    while (n < 2000 && !seen) begin
      @(negedge clk); n++;
      if (tone_if.outputTick === 1'b1) seen = 1'b1;
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if (!seen || tone_if.outputSample !== 8'd0 || tone_if.outputSampleValid !== 1'b0) begin
      fails++; $display("FAIL mid_reset_clear: got sample=%0d valid=%b tick_seen=%0d expected 0/0/1",
                        tone_if.outputSample, tone_if.outputSampleValid, seen);
    end
    stray = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (tone_if.outputSampleValid !== 1'b0) stray = 1'b1;
    end
    rst_n = 1'b1;
    n = 0;
    while (n < 2000) begin
      @(negedge clk); n++;
      if (tone_if.outputSampleValid !== 1'b0) stray = 1'b1;
      if (tone_if.outputTick === 1'b1) break;
    end
    tests++;
    if (stray) begin
      fails++; $display("FAIL mid_reset_no_valid: got a valid pulse expected none");
    end
    tests++;
    if (n !== 1562) begin
      fails++; $display("FAIL post_reset_tick: got %0d cycles expected 1562", n);
    end
  endtask

  initial begin
    test_reset();
    test_tick_cadence();
    test_square();
    test_amp_scaling();
    test_stability();
    test_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
